// File: rtl/qenc_pkg.sv
// Shared types and step decoding for the quadrature encoder counter.
package qenc_pkg;

    typedef enum logic {QE_INIT, QE_TRACK} qe_state_t;

    typedef enum logic [1:0] {QS_NONE, QS_FWD, QS_REV, QS_ERR} qe_step_t;

    // ab = {A, B}; forward Gray order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic qe_step_t qe_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        qe_step_t step;
        step = QS_NONE;
        if (cur_ab != prev_ab) begin
            if ((prev_ab ^ cur_ab) == 2'b11) begin
                step = QS_ERR;
            end else begin
                case ({prev_ab, cur_ab})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = QS_FWD;
                    default:                                step = QS_REV;
                endcase
            end
        end
        return step;
    endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Pin, control and status bundle of one quadrature encoder counter.
interface qenc_if #(
    parameter int COUNT_BITS = 16,
    parameter int ERR_BITS   = 8,
    parameter int PER_BITS   = 20
);
    logic                  inA;
    logic                  inB;
    logic                  zero_req;
    logic [COUNT_BITS-1:0] count;
    logic                  direction;
    logic                  step_stb;
    logic [ERR_BITS-1:0]   err_count;
    logic [PER_BITS-1:0]   step_period;

    modport master (
        output inA, inB, zero_req,
        input  count, direction, step_stb, err_count, step_period
    );

    modport slave (
        input  inA, inB, zero_req,
        output count, direction, step_stb, err_count, step_period
    );
endinterface

// File: rtl/quad_encoder_counter_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-cycle stability filter for one encoder pin.
module qenc_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic valid
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          cand_q, cand_d;
    logic [CW-1:0] run_q, run_d;
    logic          level_q, level_d;
    logic          valid_q, valid_d;

    // run_d counts consecutive cycles, including this one, that sync2 has held cand's level.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cand_d  = sync2_q;
        level_d = level_q;
        valid_d = valid_q;
        if (sync2_q == cand_q) begin
            run_d = (run_q >= RUN_MAX) ? run_q : run_q + CW'(1);
        end else begin
            run_d = CW'(1);
        end
        if (run_d >= RUN_MAX) begin
            level_d = sync2_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cand_q  <= 1'b0;
            run_q   <= '0;
            level_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    assign level = level_q;
    assign valid = valid_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder with wrapping position count and saturating illegal-transition count.
// Define QENC_VELOCITY_EN to add the step-period measurement; otherwise step_period is 0.
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int COUNT_BITS = 16,
    parameter int FILT_LEN   = 4,
    parameter int ERR_BITS   = 8,
    parameter int PER_BITS   = 20
) (
    input  logic   clk,
    input  logic   reset,
    qenc_if.slave  bus
);
    logic [1:0] raw_ab;
    logic [1:0] cur_ab;
    logic [1:0] valid_ab;

    assign raw_ab = {bus.inA, bus.inB};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            qenc_filter #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_ab[gi]),
                .level (cur_ab[gi]),
                .valid (valid_ab[gi])
            );
        end
    endgenerate

    qe_state_t             state_q, state_d;
    logic [1:0]            prev_ab_q, prev_ab_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  dir_q, dir_d;
    logic                  step_stb_q, step_stb_d;
    logic [ERR_BITS-1:0]   err_q, err_d;
    qe_step_t              step;

    always_comb begin
        state_d    = state_q;
        prev_ab_d  = prev_ab_q;
        count_d    = count_q;
        dir_d      = dir_q;
        step_stb_d = 1'b0;
        err_d      = err_q;
        step       = QS_NONE;
        case (state_q)
            QE_INIT: begin
                if (&valid_ab) begin
                    prev_ab_d = cur_ab;
                    state_d   = QE_TRACK;
                end
            end
            QE_TRACK: begin
                step      = qe_decode(prev_ab_q, cur_ab);
                prev_ab_d = cur_ab;
                case (step)
                    QS_FWD: begin
                        count_d    = count_q + COUNT_BITS'(1);
                        dir_d      = 1'b1;
                        step_stb_d = 1'b1;
                    end
                    QS_REV: begin
                        count_d    = count_q - COUNT_BITS'(1);
                        dir_d      = 1'b0;
                        step_stb_d = 1'b1;
                    end
                    QS_ERR: begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_BITS'(1);
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = QE_INIT;
        endcase
        // A clear request overrides any step landing in the same cycle.
        if (bus.zero_req) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= QE_INIT;
            prev_ab_q  <= 2'b00;
            count_q    <= '0;
            dir_q      <= 1'b0;
            step_stb_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_ab_q  <= prev_ab_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_stb_q <= step_stb_d;
            err_q      <= err_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.direction = dir_q;
    assign bus.step_stb  = step_stb_q;
    assign bus.err_count = err_q;

`ifdef QENC_VELOCITY_EN
    logic [PER_BITS-1:0] per_cnt_q, per_cnt_d;
    logic [PER_BITS-1:0] period_q, period_d;

    // The counter restarts at 1 so the captured value equals the cycle distance between steps.
    always_comb begin
        per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_BITS'(1);
        period_d  = period_q;
        if (step_stb_d) begin
            period_d  = per_cnt_q;
            per_cnt_d = PER_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            per_cnt_q <= '0;
            period_q  <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
        end
    end

    assign bus.step_period = period_q;
`else
    assign bus.step_period = '0;
`endif

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed self-checking bench for quad_encoder_counter (FILT_LEN=4, COUNT_BITS=16).
module tb_quad_encoder_counter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   pulses;
    int   base;

    qenc_if #(.COUNT_BITS(16), .ERR_BITS(8), .PER_BITS(20)) bus ();

    quad_encoder_counter #(
        .COUNT_BITS (16),
        .FILT_LEN   (4),
        .ERR_BITS   (8),
        .PER_BITS   (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pulses = 0;
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.step_stb === 1'b1) pulses++;
    end

    logic [1:0] fwd [0:3];
    initial begin
        fwd[0] = 2'b10; fwd[1] = 2'b11; fwd[2] = 2'b01; fwd[3] = 2'b00;
    end

    task automatic set_ab(input logic [1:0] ab);
        @(negedge clk);
        bus.inA = ab[1];
        bus.inB = ab[0];
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_zero();
        @(negedge clk);
        bus.zero_req = 1'b1;
        @(negedge clk);
        bus.zero_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.inA = 1'b0; bus.inB = 1'b0; bus.zero_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0h exp=0", bus.count); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err got=%0h exp=0", bus.err_count); end
        checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", bus.direction); end
        checks++; if (bus.step_period !== 20'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", bus.step_period); end
        @(negedge clk);
        reset = 1'b1;
        base = pulses;
        wait_neg(12);
        checks++; if (pulses - base !== 0 || bus.count !== 16'd0) begin
            errors++; $display("FAIL init_acquire pulses=%0d count=%0h exp pulses=0 count=0", pulses - base, bus.count);
        end
        $display("test_reset: count=%0h err=%0h dir=%b", bus.count, bus.err_count, bus.direction);
    endtask

    task automatic test_forward();
        base = pulses;
        set_ab(fwd[0]);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus.step_stb !== 1'b0) begin errors++; $display("FAIL latency_early stb=%b exp=0", bus.step_stb); end
        @(posedge clk);
        #1;
        checks++; if (bus.step_stb !== 1'b1) begin errors++; $display("FAIL latency_7 stb=%b exp=1", bus.step_stb); end
        wait_neg(2);
        for (int i = 1; i < 20; i++) begin
            set_ab(fwd[i % 4]);
            wait_neg(9);
        end
        checks++; if (bus.count !== 16'd20) begin errors++; $display("FAIL fwd_count got=%0d exp=20", bus.count); end
        checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b exp=1", bus.direction); end
        checks++; if (pulses - base !== 20) begin errors++; $display("FAIL fwd_pulses got=%0d exp=20", pulses - base); end
        $display("test_forward: count=%0d dir=%b pulses=%0d", bus.count, bus.direction, pulses - base);
    endtask

    task automatic test_wrap();
        pulse_zero();
        wait_neg(2);
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL zero_count got=%0h exp=0", bus.count); end
        set_ab(2'b01);
        wait_neg(9);
        checks++; if (bus.count !== 16'hFFFF) begin errors++; $display("FAIL wrap_down got=%0h exp=ffff", bus.count); end
        checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL wrap_dir got=%b exp=0", bus.direction); end
        set_ab(2'b00);
        wait_neg(9);
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL wrap_up got=%0h exp=0", bus.count); end
        checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL wrap_up_dir got=%b exp=1", bus.direction); end
        $display("test_wrap: count=%0h dir=%b", bus.count, bus.direction);
    endtask

    task automatic test_glitch();
        base = pulses;
        set_ab(2'b10);
        wait_neg(2);
        set_ab(2'b00);
        wait_neg(10);
        checks++; if (pulses - base !== 0) begin errors++; $display("FAIL glitch3_pulses got=%0d exp=0", pulses - base); end
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL glitch3_count got=%0h exp=0", bus.count); end
        set_ab(2'b10);
        wait_neg(3);
        set_ab(2'b00);
        wait_neg(4);
        checks++; if (pulses - base !== 1) begin errors++; $display("FAIL glitch4_pulses got=%0d exp=1", pulses - base); end
        checks++; if (bus.count !== 16'd1) begin errors++; $display("FAIL glitch4_count got=%0h exp=1", bus.count); end
        wait_neg(8);
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL glitch_return_count got=%0h exp=0", bus.count); end
        checks++; if (pulses - base !== 2) begin errors++; $display("FAIL glitch_return_pulses got=%0d exp=2", pulses - base); end
        $display("test_glitch: count=%0h pulses=%0d", bus.count, pulses - base);
    endtask

    task automatic test_illegal();
        base = pulses;
        set_ab(2'b11);
        wait_neg(9);
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL err_first got=%0d exp=1", bus.err_count); end
        set_ab(2'b00);
        wait_neg(9);
        checks++; if (bus.err_count !== 8'd2) begin errors++; $display("FAIL err_second got=%0d exp=2", bus.err_count); end
        checks++; if (bus.count !== 16'd0 || pulses - base !== 0) begin
            errors++; $display("FAIL err_nostep count=%0h pulses=%0d exp count=0 pulses=0", bus.count, pulses - base);
        end
        for (int i = 0; i < 258; i++) begin
            set_ab((i % 2 == 0) ? 2'b11 : 2'b00);
            wait_neg(4);
        end
        wait_neg(9);
        checks++; if (bus.err_count !== 8'hFF) begin errors++; $display("FAIL err_saturate got=%0h exp=ff", bus.err_count); end
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL err_sat_count got=%0h exp=0", bus.count); end
        $display("test_illegal: err=%0h count=%0h", bus.err_count, bus.count);
    endtask

    task automatic test_zero_collision();
        pulse_zero();
        for (int i = 0; i < 41; i++) begin
            set_ab(fwd[i % 4]);
            wait_neg(4);
        end
        wait_neg(8);
        checks++; if (bus.count !== 16'd41) begin errors++; $display("FAIL pre_zero_count got=%0d exp=41", bus.count); end
        set_ab(fwd[41 % 4]);
        repeat (6) @(negedge clk);
        bus.zero_req = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL zero_wins_count got=%0d exp=0", bus.count); end
        checks++; if (bus.step_stb !== 1'b1) begin errors++; $display("FAIL zero_wins_stb got=%b exp=1", bus.step_stb); end
        checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL zero_wins_dir got=%b exp=1", bus.direction); end
        checks++; if (bus.err_count !== 8'hFF) begin errors++; $display("FAIL zero_keeps_err got=%0h exp=ff", bus.err_count); end
        @(negedge clk);
        bus.zero_req = 1'b0;
        wait_neg(4);
        checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL zero_hold got=%0d exp=0", bus.count); end
        $display("test_zero_collision: count=%0d dir=%b err=%0h", bus.count, bus.direction, bus.err_count);
    endtask

    task automatic test_period();
        set_ab(fwd[2]);
        wait_neg(49);
        set_ab(fwd[3]);
        wait_neg(9);
`ifdef QENC_VELOCITY_EN
        checks++; if (bus.step_period !== 20'd50) begin errors++; $display("FAIL period got=%0d exp=50", bus.step_period); end
`else
        checks++; if (bus.step_period !== 20'd0) begin errors++; $display("FAIL period_off got=%0d exp=0", bus.step_period); end
`endif
        checks++; if (bus.count !== 16'd2) begin errors++; $display("FAIL period_count got=%0d exp=2", bus.count); end
        $display("test_period: period=%0d count=%0d", bus.step_period, bus.count);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_forward();
        test_wrap();
        test_glitch();
        test_illegal();
        test_zero_collision();
        test_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
